// File: rtl/mmio_arb_pkg.sv
// Shared types, widths and the rotating-priority search for the MMIO slot arbiter.
package mmio_arb_pkg;

  localparam int unsigned SLOT_ADDR_W = 5;
  localparam int unsigned SLOT_DATA_W = 32;
  localparam int unsigned MAX_REQ     = 4;
  localparam int unsigned IDX_W       = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // First asserted req in the order last+1, last+2, ... modulo n.
  function automatic logic [IDX_W-1:0] next_rr(input logic [IDX_W-1:0] last,
                                               input logic [MAX_REQ-1:0] req,
                                               input int unsigned n);
    logic [IDX_W-1:0] win;
    logic             found;
    int unsigned      idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        idx = (32'(last) + k) % n;
        if (!found && req[idx[IDX_W-1:0]]) begin
          win   = idx[IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker; the master after i_last is searched first.
module rr_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_win
);

  logic [MAX_REQ-1:0] w_req;

  always_comb begin
    w_req        = '0;
    w_req[N-1:0] = i_req;
  end

  assign o_valid = |i_req;
  assign o_win   = next_rr(i_last, w_req, N);

endmodule

// File: rtl/mmio_slot_arbiter.sv
// Round-robin sharing of one MMIO slot between N_REQ masters with a req/ack handshake.
// Each access runs IDLE -> ISSUE (slot strobe) -> ACK (ack pulse with read data).
module mmio_slot_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = SLOT_ADDR_W,
  parameter int unsigned DATA_W = SLOT_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_read,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wr_data,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       ack_rd_data,
  output logic                    busy,
  output logic                    slot_cs,
  output logic                    slot_read,
  output logic                    slot_write,
  output logic [ADDR_W-1:0]       slot_addr,
  output logic [DATA_W-1:0]       slot_wr_data,
  input  logic [DATA_W-1:0]       slot_rd_data
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_gnt;
  logic [IDX_W-1:0]   r_last;
  logic [N_REQ-1:0]   r_ack;
  logic [DATA_W-1:0]  r_ack_rd_data;
  logic               r_slot_cs;
  logic               r_slot_read;
  logic               r_slot_write;
  logic [ADDR_W-1:0]  r_slot_addr;
  logic [DATA_W-1:0]  r_slot_wr_data;

  logic               w_valid;
  logic [IDX_W-1:0]   w_win;
  logic               w_sel_read;
  logic               w_sel_write;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wr_data;
  logic [N_REQ-1:0]   w_gnt_onehot;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .i_req   (req),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_win   (w_win)
  );

  always_comb begin
    w_sel_read    = 1'b0;
    w_sel_write   = 1'b0;
    w_sel_addr    = '0;
    w_sel_wr_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == IDX_W'(i)) begin
        w_sel_read    = req_read[i];
        w_sel_write   = req_write[i];
        w_sel_addr    = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wr_data = req_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_gnt_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_gnt_onehot[i] = (r_gnt == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_gnt          <= '0;
      r_last         <= IDX_W'(N_REQ - 1);
      r_ack          <= '0;
      r_ack_rd_data  <= '0;
      r_slot_cs      <= 1'b0;
      r_slot_read    <= 1'b0;
      r_slot_write   <= 1'b0;
      r_slot_addr    <= '0;
      r_slot_wr_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_slot_cs      <= 1'b1;
            // Write wins when both qualifiers are set.
            r_slot_read    <= w_sel_read & ~w_sel_write;
            r_slot_write   <= w_sel_write;
            r_slot_addr    <= w_sel_addr;
            r_slot_wr_data <= w_sel_wr_data;
            r_gnt          <= w_win;
            r_state        <= ISSUE;
          end
        end
        ISSUE: begin
          r_slot_cs      <= 1'b0;
          r_slot_read    <= 1'b0;
          r_slot_write   <= 1'b0;
          r_slot_addr    <= '0;
          r_slot_wr_data <= '0;
          r_ack_rd_data  <= r_slot_read ? slot_rd_data : '0;
          r_ack          <= w_gnt_onehot;
          r_state        <= ACK;
        end
        ACK: begin
          r_ack         <= '0;
          r_ack_rd_data <= '0;
          r_last        <= r_gnt;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack          = r_ack;
  assign ack_rd_data  = r_ack_rd_data;
  assign busy         = (r_state != IDLE);
  assign slot_cs      = r_slot_cs;
  assign slot_read    = r_slot_read;
  assign slot_write   = r_slot_write;
  assign slot_addr    = r_slot_addr;
  assign slot_wr_data = r_slot_wr_data;

endmodule

// File: tb/tb_mmio_slot_arbiter.sv
// Directed bench for mmio_slot_arbiter: 2-master and 4-master instances, ack scoreboard.
module tb_mmio_slot_arbiter;

  logic clk;
  logic rst;

  logic [1:0]  req2, rd2, wr2, ack2;
  logic [9:0]  addr2;
  logic [63:0] wd2;
  logic [31:0] ack_rd2, swd2, srdata2;
  logic        busy2, cs2, srd2, swr2;
  logic [4:0]  saddr2;

  logic [3:0]   req4, rd4, wr4, ack4;
  logic [19:0]  addr4;
  logic [127:0] wd4;
  logic [31:0]  ack_rd4, swd4, srdata4;
  logic         busy4, cs4, srd4, swr4;
  logic [4:0]   saddr4;

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    return 32'hDEAD_BEE8 ^ {27'd0, a};
  endfunction

  assign srdata2 = cs2 ? rd_model(saddr2) : 32'h0;
  assign srdata4 = cs4 ? rd_model(saddr4) : 32'h0;

  mmio_slot_arbiter #(.N_REQ(2), .ADDR_W(5), .DATA_W(32)) u_dut2 (
    .clk (clk), .rst (rst), .req (req2), .req_read (rd2), .req_write (wr2),
    .req_addr (addr2), .req_wr_data (wd2), .ack (ack2), .ack_rd_data (ack_rd2),
    .busy (busy2), .slot_cs (cs2), .slot_read (srd2), .slot_write (swr2),
    .slot_addr (saddr2), .slot_wr_data (swd2), .slot_rd_data (srdata2)
  );

  mmio_slot_arbiter #(.N_REQ(4), .ADDR_W(5), .DATA_W(32)) u_dut4 (
    .clk (clk), .rst (rst), .req (req4), .req_read (rd4), .req_write (wr4),
    .req_addr (addr4), .req_wr_data (wd4), .ack (ack4), .ack_rd_data (ack_rd4),
    .busy (busy4), .slot_cs (cs4), .slot_read (srd4), .slot_write (swr4),
    .slot_addr (saddr4), .slot_wr_data (swd4), .slot_rd_data (srdata4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ack(input string tag, input logic [3:0] ack_v, input logic [31:0] data);
    exp_t        e;
    logic [3:0]  oh;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s: observed ack %0h expected no ack", tag, ack_v);
    end else begin
      e  = sb.pop_front();
      oh = 4'b0001 << e.idx;
      chk({tag, "_ack"}, 64'(ack_v), 64'(oh));
      chk({tag, "_data"}, 64'(data), 64'(e.data));
    end
  endtask

  task automatic push_exp(input int unsigned idx, input logic [31:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  initial begin
    int last_c;
    int n_ack;
    n_cmp  = 0;
    n_fail = 0;
    req2 = '0; rd2 = '0; wr2 = '0; addr2 = '0; wd2 = '0;
    req4 = '0; rd4 = '0; wr4 = '0; addr4 = '0; wd4 = '0;
    rst  = 1'b1;
    tick();
    tick();
    chk("rst_ack", 64'(ack2), 64'(0));
    chk("rst_busy", 64'(busy2), 64'(0));
    chk("rst_cs", 64'(cs2), 64'(0));
    chk("rst_rdata", 64'(ack_rd2), 64'(0));
    chk("rst_busy4", 64'(busy4), 64'(0));
    rst = 1'b0;
    tick();

    // Single write from master 0
    req2 = 2'b01; wr2 = 2'b01; addr2[4:0] = 5'h03; wd2[31:0] = 32'h0000_000A;
    push_exp(0, 32'h0);
    tick();
    chk("wr_cs", 64'(cs2), 64'(1));
    chk("wr_write", 64'(swr2), 64'(1));
    chk("wr_read", 64'(srd2), 64'(0));
    chk("wr_addr", 64'(saddr2), 64'(5'h03));
    chk("wr_wdata", 64'(swd2), 64'(32'hA));
    chk("wr_busy1", 64'(busy2), 64'(1));
    chk("wr_noack", 64'(ack2), 64'(0));
    tick();
    check_ack("wr", {2'b00, ack2}, ack_rd2);
    chk("wr_busy2", 64'(busy2), 64'(1));
    chk("wr_cs_off", 64'(cs2), 64'(0));
    chk("wr_addr_off", 64'(saddr2), 64'(0));
    req2 = '0; wr2 = '0;
    tick();
    chk("wr_idle", 64'(busy2), 64'(0));
    chk("wr_ack_off", 64'(ack2), 64'(0));

    // Single read from master 1
    req2 = 2'b10; rd2 = 2'b10; addr2[9:5] = 5'h07;
    push_exp(1, 32'hDEAD_BEEF);
    tick();
    chk("rd_read", 64'(srd2), 64'(1));
    chk("rd_write", 64'(swr2), 64'(0));
    chk("rd_addr", 64'(saddr2), 64'(5'h07));
    tick();
    check_ack("rd", {2'b00, ack2}, ack_rd2);
    req2 = '0; rd2 = '0;
    tick();

    // Contention straight after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req2 = 2'b11; wr2 = 2'b11; addr2 = {5'h02, 5'h01};
    push_exp(0, 32'h0); push_exp(1, 32'h0); push_exp(0, 32'h0); push_exp(1, 32'h0);
    last_c = -1;
    n_ack  = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack2 != 2'b00) begin
        check_ack("cont", {2'b00, ack2}, ack_rd2);
        if (last_c >= 0) chk("cont_gap", 64'(c - last_c), 64'(3));
        last_c = c;
        n_ack++;
      end
    end
    chk("cont_nack", 64'(n_ack), 64'(4));
    chk("cont_sb", 64'(sb.size()), 64'(0));
    req2 = '0; wr2 = '0;
    tick();

    // Conflicting qualifiers, then no qualifier
    req2 = 2'b01; rd2 = 2'b01; wr2 = 2'b01; addr2[4:0] = 5'h04; wd2[31:0] = 32'h5;
    push_exp(0, 32'h0);
    tick();
    chk("both_write", 64'(swr2), 64'(1));
    chk("both_read", 64'(srd2), 64'(0));
    tick();
    check_ack("both", {2'b00, ack2}, ack_rd2);
    req2 = '0; rd2 = '0; wr2 = '0;
    tick();
    req2 = 2'b10; addr2[9:5] = 5'h09;
    push_exp(1, 32'h0);
    tick();
    chk("none_cs", 64'(cs2), 64'(1));
    chk("none_strb", 64'({srd2, swr2}), 64'(0));
    tick();
    check_ack("none", {2'b00, ack2}, ack_rd2);
    req2 = '0;
    tick();

    // Reset during ISSUE
    req2 = 2'b01; wr2 = 2'b01; addr2[4:0] = 5'h0C;
    tick();
    chk("mid_pre_cs", 64'(cs2), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_cs", 64'(cs2), 64'(0));
    chk("mid_busy", 64'(busy2), 64'(0));
    chk("mid_addr", 64'(saddr2), 64'(0));
    tick();
    chk("mid_noack", 64'(ack2), 64'(0));
    rst = 1'b0;
    push_exp(0, 32'h0);
    tick();
    chk("mid_re_cs", 64'(cs2), 64'(1));
    chk("mid_re_addr", 64'(saddr2), 64'(5'h0C));
    tick();
    check_ack("mid", {2'b00, ack2}, ack_rd2);
    req2 = '0; wr2 = '0;
    tick();

    // Four masters: serve master 2, then 0, 1 and 3 contend
    req4 = 4'b0100; rd4 = 4'b0100; addr4[14:10] = 5'd2;
    push_exp(2, rd_model(5'd2));
    tick();
    chk("n4_cs", 64'(cs4), 64'(1));
    tick();
    check_ack("n4_first", ack4, ack_rd4);
    req4 = '0; rd4 = '0;
    tick();
    req4 = 4'b1011; rd4 = 4'b1011;
    addr4 = {5'd13, 5'd12, 5'd11, 5'd10};
    push_exp(3, rd_model(5'd13)); push_exp(0, rd_model(5'd10)); push_exp(1, rd_model(5'd11));
    n_ack = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack4 != 4'b0000) begin
        check_ack("n4_rot", ack4, ack_rd4);
        req4 = req4 & ~ack4;
        n_ack++;
      end
    end
    chk("n4_nack", 64'(n_ack), 64'(3));
    chk("n4_sb", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_slot_arbiter.md
Name: mmio_slot_arbiter

Overview:
- Round-robin arbiter sharing one MMIO slot interface (cs/read/write/addr/wr_data/rd_data) between N_REQ bus masters, e.g. the CPU bridge and an LED pattern sequencer driving the same GPO slot core.
- Each master issues one access at a time using a req/ack handshake.
- The arbiter drives a registered, single-cycle slot strobe and returns the read data with ack.
- Sits between the masters and the slot decoder/core.

Parameters:
- N_REQ, 2, number of requesting masters, legal range 2..4.
- ADDR_W, 5, slot register address width.
- DATA_W, 32, slot data width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- req  input  N_REQ  per-master access request; held high until ack
- req_read  input  N_REQ  per-master read qualifier
- req_write  input  N_REQ  per-master write qualifier
- req_addr  input  N_REQ*ADDR_W  per-master address, packed, master i at [i*ADDR_W +: ADDR_W]
- req_wr_data  input  N_REQ*DATA_W  per-master write data, packed likewise
- ack  output  N_REQ  one-cycle completion pulse to the granted master
- ack_rd_data  output  DATA_W  read data, valid only while ack is high
- busy  output  1  high in any state other than IDLE
- slot_cs  output  1  slot chip select
- slot_read  output  1  slot read strobe
- slot_write  output  1  slot write strobe
- slot_addr  output  ADDR_W  slot address
- slot_wr_data  output  DATA_W  slot write data
- slot_rd_data  input  DATA_W  slot read data, combinational from the slot and valid while slot_cs is high

Behaviour:
- Reset value of every output is 0. State = IDLE; grant pointer last = N_REQ-1, so master 0 has highest priority first.
- FSM states:
  - IDLE: if any req is high, choose the winner, register its read/write/addr/wr_data into the slot output registers and its index into gnt, then go to ISSUE. Otherwise stay in IDLE with all slot outputs at 0.
  - ISSUE (exactly 1 cycle): slot_cs = 1 and slot_read/slot_write per the latched qualifiers. Capture slot_rd_data into the read data register if the access is a read, else load 0. Go to ACK.
  - ACK (exactly 1 cycle): ack[gnt] = 1, ack_rd_data = captured data, all slot strobes 0. Set last = gnt and go to IDLE.
- Latency: req sampled high at edge t -> slot strobe in cycle t+1 -> ack in cycle t+2. Throughput is one access per 3 cycles.
- Round-robin: search order is last+1, last+2, ... modulo N_REQ, and the first asserted req wins. A master that has just been served is lowest priority on the next arbitration.
- Handshake rules:
  - A master keeps req and its qualifiers stable from assertion until ack.
  - A master deasserts req in the cycle after ack; a req still high in IDLE is treated as a new request.
  - Changes on a non-granted master's inputs have no effect until it is granted.
- Qualifier rules:
  - read and write both high: treated as a write only; slot_read = 0.
  - Neither high: ISSUE still asserts slot_cs with no strobe, and ack still pulses with data 0.
- slot_addr and slot_wr_data hold their latched value during ISSUE and return to 0 in ACK and IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0; an in-flight ack is lost and the master re-issues its request.
- Requests arriving during ISSUE or ACK wait for the next IDLE cycle.

Decomposition:
- Package mmio_arb_pkg:
  - state_t enum {IDLE, ISSUE, ACK}
  - SLOT_ADDR_W = 5, SLOT_DATA_W = 32
  - function next_rr(last, req) returning the winner index
- Sub-module rr_arbiter: combinational rotating-priority picker with parameter N.
  - Inputs: req[N], last index.
  - Outputs: valid, win index.
  - Instantiated once in the top FSM.

Test Plan:
- Single write: master0 req_write = 1, addr = 5'h03, wr_data = 32'h0000_000A at t -> cycle t+1 slot_cs = 1, slot_write = 1, slot_addr = 3, slot_wr_data = 0xA; cycle t+2 ack = 2'b01; busy high for t+1..t+2.
- Single read: master1 reads addr 5'h07 with slot_rd_data = 32'hDEAD_BEEF during ISSUE -> ack = 2'b10 and ack_rd_data = 0xDEADBEEF at t+2; slot_write stays 0.
- Contention: both masters request continuously after reset -> grant order 0,1,0,1 and one ack every 3 cycles; neither master gets two consecutive grants.
- Conflict qualifiers: master0 with read = 1 and write = 1 -> slot_write = 1, slot_read = 0. Master1 with neither -> slot_cs = 1 with no strobe, then ack with ack_rd_data = 0.
- Reset mid-access: assert rst during ISSUE -> all outputs 0 immediately, no ack. After release with req still high -> fresh access to master0.
- N_REQ = 4 rotation: last = 2, requests from masters 0, 1 and 3 -> order 3, 0, 1.
